// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with enable, selectable output polarity and an
// auto-scan mode in which a prescaler steps the decoded index through channels
// 0..NUM_CH-1 (multiplexed digit selects, time-sliced peripheral selects).
module decoder_scan #(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DIV_W      = 16,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      i,
  input  logic [DIV_W-1:0]      div,
  output logic [2**SEL_W-1:0]   o,
  output logic [SEL_W-1:0]      idx,
  output logic                  step,
  output logic                  wrap
);

  localparam int unsigned      OutW    = 2**SEL_W;
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_CH - 1);
  localparam logic [OutW-1:0]  Inactive = {OutW{ACTIVE_LOW}};

  logic [SEL_W-1:0] r_idx;
  logic [DIV_W-1:0] r_cnt;
  logic [OutW-1:0]  r_o;
  logic             r_step;
  logic             r_wrap;

  logic [SEL_W-1:0] w_idx_d;
  logic [DIV_W-1:0] w_cnt_d;
  logic             w_step_d;
  logic             w_wrap_d;
  logic             w_cur_ok;
  logic             w_next_ok;
  logic [OutW-1:0]  w_dec;
  logic [OutW-1:0]  w_o_d;

  // Range checks of the current and next index against the channels in use.
  always_comb begin
    w_cur_ok  = ({{(32-SEL_W){1'b0}}, r_idx} < NUM_CH);
    w_next_ok = ({{(32-SEL_W){1'b0}}, w_idx_d} < NUM_CH);
  end

  // Next index / prescaler / pulse state; en has priority over mode.
  always_comb begin
    w_idx_d  = r_idx;
    w_cnt_d  = r_cnt;
    w_step_d = 1'b0;
    w_wrap_d = 1'b0;
    if (en) begin
      if (!mode) begin
        // Direct decode: follow i, keep prescaler parked at 0.
        w_idx_d = i;
        w_cnt_d = '0;
      end else if (!w_cur_ok) begin
        // Entering scan from an out-of-range direct index: snap to channel 0
        // silently and restart the dwell.
        w_idx_d = '0;
        w_cnt_d = '0;
      end else if (r_cnt >= div) begin
        // >= so a div lowered below the running count advances immediately.
        w_cnt_d  = '0;
        w_step_d = 1'b1;
        if (r_idx == LastIdx) begin
          w_idx_d  = '0;
          w_wrap_d = 1'b1;
        end else begin
          w_idx_d = r_idx + SEL_W'(1);
        end
      end else begin
        w_cnt_d = r_cnt + DIV_W'(1);
      end
    end
  end

  // One-hot decode of the next index by comparison loop (elaborates for any SEL_W).
  always_comb begin
    w_dec = '0;
    for (int k = 0; k < int'(OutW); k++) begin
      w_dec[k] = (w_idx_d == SEL_W'(k));
    end
  end

  // Output value: decoded channel when enabled and in range, else inactive.
  always_comb begin
    w_o_d = Inactive;
    if (en && w_next_ok) begin
      w_o_d = w_dec ^ Inactive;
    end
  end

  // State and registered outputs; synchronous reset discards any partial dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_o    <= Inactive;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_idx  <= w_idx_d;
      r_cnt  <= w_cnt_d;
      r_o    <= w_o_d;
      r_step <= w_step_d;
      r_wrap <= w_wrap_d;
    end
  end

  assign o    = r_o;
  assign idx  = r_idx;
  assign step = r_step;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: two instances share stimulus (NUM_CH=3 active-high,
// NUM_CH=4 active-low). A reference model pushes expected outputs into per-instance
// queues before each edge; they are popped and compared after the edge, alongside
// directed constant checks.
module tb_decoder_scan;

  typedef struct packed {
    logic [3:0] o;
    logic [1:0] idx;
    logic       step;
    logic       wrap;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] div;

  logic [3:0] o_a, o_b;
  logic [1:0] idx_a, idx_b;
  logic       step_a, step_b, wrap_a, wrap_b;

  int total = 0;
  int bad   = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   ma_idx, ma_cnt, mb_idx, mb_cnt;

  decoder_scan #(.SEL_W(2), .NUM_CH(3), .DIV_W(16), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .i(sel), .div(div),
    .o(o_a), .idx(idx_a), .step(step_a), .wrap(wrap_a)
  );

  decoder_scan #(.SEL_W(2), .NUM_CH(4), .DIV_W(16), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .i(sel), .div(div),
    .o(o_b), .idx(idx_b), .step(step_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after the coming edge, from the current inputs and model state.
  function automatic exp_t model(input int nc, input bit al, inout int mi, inout int mc);
    exp_t e;
    bit   act;
    e   = '0;
    act = 1'b0;
    if (rst) begin
      mi = 0;
      mc = 0;
    end else if (en) begin
      if (!mode) begin
        mi = int'(sel);
        mc = 0;
      end else if (mi >= nc) begin
        mi = 0;
        mc = 0;
      end else if (mc >= int'(div)) begin
        mc     = 0;
        e.step = 1'b1;
        if (mi == nc - 1) begin
          mi     = 0;
          e.wrap = 1'b1;
        end else begin
          mi = mi + 1;
        end
      end else begin
        mc = mc + 1;
      end
      act = (mi < nc);
    end
    e.idx = 2'(mi);
    e.o   = act ? (4'b0001 << mi) : 4'b0000;
    if (al) e.o = ~e.o;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: push model expectations, clock, then pop and compare all outputs.
  task automatic tick();
    exp_t ea, eb;
    q_a.push_back(model(3, 1'b0, ma_idx, ma_cnt));
    q_b.push_back(model(4, 1'b1, mb_idx, mb_cnt));
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk("a_o", 32'(o_a), 32'(ea.o));
    chk("a_idx", 32'(idx_a), 32'(ea.idx));
    chk("a_step", 32'(step_a), 32'(ea.step));
    chk("a_wrap", 32'(wrap_a), 32'(ea.wrap));
    chk("b_o", 32'(o_b), 32'(eb.o));
    chk("b_idx", 32'(idx_b), 32'(eb.idx));
    chk("b_step", 32'(step_b), 32'(eb.step));
    chk("b_wrap", 32'(wrap_b), 32'(eb.wrap));
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0; div = 16'd0;
    ma_idx = 0; ma_cnt = 0; mb_idx = 0; mb_cnt = 0;

    // Reset and polarity
    tick();
    tick();
    chk("rst_a_o", 32'(o_a), 32'h0);
    chk("rst_b_o", 32'(o_b), 32'hf);
    chk("rst_a_idx", 32'(idx_a), 32'h0);
    chk("rst_a_step", 32'(step_a), 32'h0);

    // Direct decode, one cycle latency
    rst = 1'b0; en = 1'b1; mode = 1'b0;
    sel = 2'd0; tick();
    chk("dir0_a", 32'(o_a), 32'h1);
    chk("dir0_b", 32'(o_b), 32'he);
    sel = 2'd1; tick();
    chk("dir1_a", 32'(o_a), 32'h2);
    sel = 2'd2; tick();
    chk("dir2_a", 32'(o_a), 32'h4);
    sel = 2'd3; tick();
    chk("dir3_a_oor_o", 32'(o_a), 32'h0);
    chk("dir3_a_oor_idx", 32'(idx_a), 32'h3);
    chk("dir3_b", 32'(o_b), 32'h7);

    // Disable: inactive output, idx held
    en = 1'b0; tick();
    chk("dis_a_o", 32'(o_a), 32'h0);
    chk("dis_b_o", 32'(o_b), 32'hf);
    chk("dis_a_idx", 32'(idx_a), 32'h3);

    // Direct->scan from out-of-range idx: snap to 0 with no pulse
    en = 1'b1; mode = 1'b1; div = 16'd2; tick();
    chk("snap_a_idx", 32'(idx_a), 32'h0);
    chk("snap_a_o", 32'(o_a), 32'h1);
    chk("snap_a_step", 32'(step_a), 32'h0);
    chk("snap_a_wrap", 32'(wrap_a), 32'h0);

    // Dwell of div+1 = 3 cycles, wrap after channel 2 (1000 never driven)
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("scan_idx", 32'(idx_a), 32'((k / 3) % 3));
      chk("scan_o", 32'(o_a), 32'(4'b0001 << ((k / 3) % 3)));
      chk("scan_step", 32'(step_a), 32'(k % 3 == 0));
      chk("scan_wrap", 32'(wrap_a), 32'(k == 9));
    end

    // div=0 advances every cycle
    div = 16'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("div0_step", 32'(step_a), 32'h1);
    end

    // Long dwell interrupted by lowering div below the running count
    div = 16'd20;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("div20_step", 32'(step_a), 32'h0);
    end
    div = 16'd4; tick();
    chk("divdrop_step", 32'(step_a), 32'h1);

    // Disable in scan freezes index
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("scan_dis_o", 32'(o_a), 32'h0);
    end

    // Reset mid-dwell at idx=2, cnt=1
    en = 1'b1; div = 16'd2;
    n = 0;
    while (!(ma_idx == 2 && ma_cnt == 1) && n < 20) begin
      tick();
      n++;
    end
    chk("reach_mid", 32'(n < 20), 32'h1);
    rst = 1'b1; tick();
    chk("midrst_o", 32'(o_a), 32'h0);
    chk("midrst_idx", 32'(idx_a), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_s1", 32'(step_a), 32'h0);
    tick();
    chk("post_rst_s2", 32'(step_a), 32'h0);
    tick();
    chk("post_rst_s3", 32'(step_a), 32'h1);
    chk("post_rst_idx", 32'(idx_a), 32'h1);

    // Scan->direct
    mode = 1'b0; sel = 2'd1; tick();
    chk("back_dir_o", 32'(o_a), 32'h2);
    chk("back_dir_step", 32'(step_a), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
